mux4_rr_sched: RTL and testbench
================================

Name: mux4_rr_sched

Overview:
- Round-robin scheduler sharing one 4:1 data mux among four requesters.
- Each requester has a request line and a W-bit data word. The block grants one requester at a time and drives the mux select.
- The selected word is presented to a single downstream consumer over a valid/ready handshake.
- A burst limit guarantees fairness. The block sits between four producer channels and one shared sink.

Parameters:
- W, 8, data width per channel.
- MAX_BURST, 4, maximum accepted transfers per grant before forced release (legal range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  per-channel request, level, held while channel has data.
- d  input  4*W  packed channel data, channel i at d[i*W +: W].
- out_ready  input  1  sink accepts y this cycle.
- y  output  W  selected data, d[sel] combinational.
- out_valid  output  1  grant[sel] & req[sel], combinational.
- grant  output  4  registered one-hot grant, 0 when idle.
- sel  output  2  registered mux select, index of grant.
- busy  output  1  registered, 1 in GRANT state.

Behaviour:
- Reset (async, immediate, also mid-burst):
  - state=IDLE, grant=0, sel=0, busy=0, ptr=0, cnt=0.
  - out_valid=0 while rst high.
  - y = d[0] during reset.
- Two states: IDLE and GRANT. ptr (2b) is the search start index; cnt counts accepted transfers in the current grant.
- Arbitration function:
  - Take the first i with req[i]=1, searching cyclically ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - No winner means IDLE.
- IDLE:
  - If any req at a rising edge, go to GRANT at that edge with grant=onehot(winner), sel=winner, cnt=0.
  - Latency is 1 cycle from req sampled high to grant/out_valid.
- GRANT transfers:
  - A transfer occurs on a cycle with out_valid & out_ready.
  - Each transfer increments cnt (width clog2(MAX_BURST+1)).
- GRANT release, evaluated at each edge. Release occurs if either:
  - req[sel]=0, or
  - a transfer occurs with cnt==MAX_BURST-1.
- On release:
  - ptr=sel+1 (wraps 3->0). Arbitrate at the same edge, searching from sel+1.
  - The released channel is eligible only after the other three (searched last).
  - Winner: GRANT with new sel, cnt=0, no idle bubble. No winner: IDLE, grant=0, busy=0.
- Burst-limited channel alone requesting: re-granted at the next edge, cnt=0. One transfer per grant cycle continues uninterrupted.
- No release: grant, sel and ptr hold. out_ready=0 stalls indefinitely with no timeout.
- Simultaneous req[sel] drop and final burst transfer: single release. The transfer does not count because out_valid=0.
- Requests of non-granted channels never affect the current grant. Requests arriving mid-burst wait.
- A channel may change d[sel] every cycle. y is not registered; sink samples on transfer.
- grant is always one-hot or zero; sel is valid only when busy=1.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=1'b0, GRANT=1'b1;
  - NCH=4 and SELW=2 constants.
- One sub-module is natural: mux4_w, a parameterised W-bit 4:1 combinational mux (case on sel, default 0). Instantiated once for y.
- Priority search, state register and counter stay in mux4_rr_sched.

Test Plan:
- Reset/idle:
  - Stimulus: rst=1 mid-grant with req=4'b1111.
  - Required: grant=0, busy=0, out_valid=0 immediately. After release with req=4'b0100: grant=4'b0100, sel=2 one edge later.
- Round robin:
  - Stimulus: req=4'b1111, out_ready=1, MAX_BURST=4, d0..d3=8'hA0..8'hA3.
  - Required: sel sequence 0,1,2,3,0. Each grant lasts exactly 4 cycles; y shows 4 each of A0, A1, A2, A3.
- Early drop:
  - Stimulus: channel 1 granted, req[1] falls after 2 transfers, req[3]=1.
  - Required: at the next edge grant=4'b1000, sel=3, cnt=0, no idle cycle.
- Backpressure:
  - Stimulus: channel 2 granted, out_ready=0 for 10 cycles, then 1.
  - Required: grant held 10 cycles, out_valid=1 throughout. Release only after 4 accepted transfers.
- Lone requester:
  - Stimulus: req=4'b0001 constant, out_ready=1.
  - Required: grant stays 4'b0001, cnt wraps 0..3 repeatedly, transfers every cycle.
- Fairness after release:
  - Stimulus: channel 3 releases with req=4'b1001.
  - Required: next grant is channel 0 (ptr wraps), not channel 3.

Source files
------------

// File: rtl/mux4_rr_sched_pkg.sv
// Shared constants, state encoding and arbitration helpers for the
// round-robin 4:1 mux scheduler.
package mux4_rr_sched_pkg;

    localparam int unsigned NCH  = 4;
    localparam int unsigned SELW = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    typedef struct packed {
        logic            found;
        logic [SELW-1:0] idx;
    } pick_t;

    // First requester at or after start, searching cyclically.
    // Scanning from the far end lets the nearest hit overwrite the others.
    function automatic pick_t rr_pick(input logic [NCH-1:0]  req,
                                      input logic [SELW-1:0] start);
        pick_t           p;
        logic [SELW-1:0] idx;
        p = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = start + SELW'(i);
            if (req[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

    function automatic logic [NCH-1:0] onehot(input logic [SELW-1:0] i);
        return NCH'(1) << i;
    endfunction

endpackage

// File: rtl/mux4_rr_sched_if.sv
// Bundle of the four producer channels and the single valid/ready sink
// served by mux4_rr_sched.
interface mux4_rr_sched_if
    import mux4_rr_sched_pkg::*;
#(
    parameter int unsigned W = 8
) ();

    logic [NCH-1:0]   req;
    logic [NCH*W-1:0] d;
    logic             out_ready;
    logic [W-1:0]     y;
    logic             out_valid;
    logic [NCH-1:0]   grant;
    logic [SELW-1:0]  sel;
    logic             busy;

    // Producer/sink side.
    modport master (
        output req,
        output d,
        output out_ready,
        input  y,
        input  out_valid,
        input  grant,
        input  sel,
        input  busy
    );

    // Scheduler side.
    modport slave (
        input  req,
        input  d,
        input  out_ready,
        output y,
        output out_valid,
        output grant,
        output sel,
        output busy
    );

endinterface

// File: rtl/mux4_rr_sched_mux4_w.sv
// Parameterised W-bit 4:1 combinational data mux.
module mux4_w #(
    parameter int unsigned W = 8
) (
    input  logic [1:0]     sel,
    input  logic [4*W-1:0] d,
    output logic [W-1:0]   y
);

    always_comb begin
        y = '0;
        case (sel)
            2'd0:    y = d[0*W +: W];
            2'd1:    y = d[1*W +: W];
            2'd2:    y = d[2*W +: W];
            2'd3:    y = d[3*W +: W];
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler granting one of four requesters at a time onto a
// shared valid/ready sink, with a per-grant burst limit for fairness.
module mux4_rr_sched
    import mux4_rr_sched_pkg::*;
#(
    parameter int unsigned W         = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input logic            clk,
    input logic            rst,
    mux4_rr_sched_if.slave bus
);

    localparam int unsigned   CW       = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

    state_e          state_q, state_d;
    logic [NCH-1:0]  grant_q, grant_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_valid;
    logic            transfer;
    logic            rel;
    pick_t           pick;

    assign out_valid     = grant_q[sel_q] & bus.req[sel_q];
    assign transfer      = out_valid & bus.out_ready;
    assign bus.out_valid = out_valid;
    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = (state_q == GRANT);

    mux4_w #(
        .W (W)
    ) u_mux (
        .sel (sel_q),
        .d   (bus.d),
        .y   (bus.y)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        rel     = 1'b0;
        pick    = '0;

        unique case (state_q)
            IDLE: begin
                pick = rr_pick(bus.req, ptr_q);
                if (pick.found) begin
                    state_d = GRANT;
                    grant_d = onehot(pick.idx);
                    sel_d   = pick.idx;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                rel = !bus.req[sel_q] || (transfer && (cnt_q == LAST_CNT));
                if (rel) begin
                    // Search from sel+1 so the released channel is tried last.
                    ptr_d = sel_q + SELW'(1);
                    pick  = rr_pick(bus.req, ptr_d);
                    cnt_d = '0;
                    if (pick.found) begin
                        grant_d = onehot(pick.idx);
                        sel_d   = pick.idx;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (transfer) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed self-checking bench for mux4_rr_sched (W=8, MAX_BURST=4).
module tb_mux4_rr_sched;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    mux4_rr_sched_if #(.W(8)) bus ();

    mux4_rr_sched #(
        .W         (8),
        .MAX_BURST (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req       = 4'b0000;
        bus.out_ready = 1'b0;
        #2;
        rst           = 1'b0;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.req       = 4'b0000;
        bus.out_ready = 1'b0;
        bus.d         = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        tick();
        tick();
        chk("rst_grant", bus.grant, 4'b0000);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_y", bus.y, 8'hA0);

        // Reset asserted in the middle of a grant.
        rst     = 1'b0;
        bus.req = 4'b1111;
        tick();
        chk("first_grant", bus.grant, 4'b0001);
        chk("first_valid", bus.out_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_grant", bus.grant, 4'b0000);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_valid", bus.out_valid, 1'b0);
        chk("midrst_y", bus.y, 8'hA0);
        bus.req = 4'b0100;
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_idle", bus.grant, 4'b0000);
        tick();
        chk("post_rst_grant", bus.grant, 4'b0100);
        chk("post_rst_sel", bus.sel, 2);

        // Round robin with all four requesting.
        do_reset();
        bus.req       = 4'b1111;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("rr_sel", bus.sel, (k / 4) % 4);
            chk("rr_y", bus.y, 8'hA0 + (k / 4) % 4);
            chk("rr_valid", bus.out_valid, 1'b1);
        end

        // Early drop after two transfers, then fairness on ch3 release.
        do_reset();
        bus.req       = 4'b1010;
        bus.out_ready = 1'b1;
        tick();
        chk("ed_grant", bus.grant, 4'b0010);
        chk("ed_sel", bus.sel, 1);
        tick();
        tick();
        bus.req = 4'b1000;
        #1;
        chk("ed_drop_valid", bus.out_valid, 1'b0);
        tick();
        chk("ed_new_grant", bus.grant, 4'b1000);
        chk("ed_new_sel", bus.sel, 3);
        chk("ed_no_bubble", bus.busy, 1'b1);
        chk("ed_new_y", bus.y, 8'hA3);
        bus.req = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ed_hold", bus.grant, 4'b1000);
        end
        tick();
        chk("fair_grant", bus.grant, 4'b0001);
        chk("fair_sel", bus.sel, 0);

        // Backpressure on channel 2.
        do_reset();
        bus.req = 4'b0100;
        tick();
        chk("bp_grant", bus.grant, 4'b0100);
        bus.req = 4'b0101;
        for (int k = 0; k < 10; k++) begin
            chk("bp_hold", bus.grant, 4'b0100);
            chk("bp_valid", bus.out_valid, 1'b1);
            tick();
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_burst", bus.grant, 4'b0100);
        end
        tick();
        chk("bp_release", bus.grant, 4'b0001);

        // Lone requester keeps being re-granted without a gap.
        do_reset();
        bus.req       = 4'b0001;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("lone_grant", bus.grant, 4'b0001);
            chk("lone_valid", bus.out_valid, 1'b1);
        end

        // Drop to idle when nothing else requests.
        bus.req = 4'b0000;
        #1;
        chk("idle_valid", bus.out_valid, 1'b0);
        tick();
        chk("idle_grant", bus.grant, 4'b0000);
        chk("idle_busy", bus.busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
